radix4_sdf_gather: RTL and testbench
====================================

// Module: radix4_sdf_gather
// PURPOSE
//  Input stage of one radix-4 FFT stage. Takes a serial complex stream of N-point frames, one sample per valid cycle.
//  Buffers the first three quarters of each frame.
//  When quarter-3 sample k arrives, presents x[k], x[k+N/4], x[k+N/2], x[k+3N/4] in parallel.
//  Also issues the twiddle exponents k, 2k, 3k for the twiddle ROM; these feed butterfly_radix4 a/b/c/d and w0/w1/w2.
// PARAMETERS
//  WIDTH   32   bit width of each real/imag data component (signed)
//  N       64   frame length in complex samples; power of 4, >=16
//  LOG2N   $clog2(N)   localparam, not overridable; exponent port width
// PORTS
//  clock     in   1      single clock, all logic on rising edge
//  reset     in   1      synchronous, active-high
//  in_valid  in   1      input sample present this cycle
//  in_sof    in   1      qualified by in_valid: sample is index 0 of a new frame
//  in_re     in   WIDTH  input sample real part, signed
//  in_im     in   WIDTH  input sample imag part, signed
//  out_valid out  1      ar..di and exponents valid this cycle
//  out_last  out  1      with out_valid: last butterfly of frame (k=N/4-1)
//  ar,ai     out  WIDTH  x[k]
//  br,bi     out  WIDTH  x[k+N/4]
//  cr,ci     out  WIDTH  x[k+N/2]
//  dr,di     out  WIDTH  x[k+3N/4]
//  w0_exp    out  LOG2N  twiddle exponent k (pairs with b)
//  w1_exp    out  LOG2N  twiddle exponent 2k (pairs with c)
//  w2_exp    out  LOG2N  twiddle exponent 3k (pairs with d)
// BEHAVIOUR
//  - Reset: all outputs 0, out_valid=0, out_last=0, idx=0. Buffer RAM is not reset; its contents are don't-care.
//  - idx[LOG2N-1:0] counts accepted samples. Quarter q=idx[LOG2N-1:LOG2N-2]; offset k=idx[LOG2N-3:0].
//  - State = q. FILL0/FILL1/FILL2 (q=0..2): write sample to buf_q[k]; no output.
//    EMIT (q=3): read buf0[k], buf1[k], buf2[k]; register them with the live input as d.
//  - idx advances only on in_valid and wraps N-1 -> 0 (EMIT -> FILL0).
//    in_valid=0: idx, buffers and state hold.
//  - Latency: outputs registered exactly 1 cycle after the accepting EMIT cycle.
//    out_valid is 1 for exactly that cycle, else 0. Data/exp outputs hold their last value when out_valid=0.
//  - Exponents: w0_exp=k, w1_exp=2k, w2_exp=3k, zero-extended to LOG2N. Max 3(N/4-1)<N, so no modulo or overflow.
//  - out_last=1 with out_valid when k=N/4-1.
//  - No backpressure: the downstream butterfly accepts every cycle.
//    Back-to-back frames need no idle cycle. buf_q[k] of frame f+1 is written only after EMIT of frame f has read it.
//  - in_sof && in_valid: sample is taken as idx=0 (written to buf0[0]) and idx becomes 1, whatever the old idx.
//    Any partial frame is silently dropped; no output is produced for it.
//  - in_sof at idx=0 is a no-op relative to normal counting. in_sof without in_valid is ignored.
//  - Reset mid-frame: on the next cycle out_valid=0 and idx=0. No output from the partial frame ever appears.
//  - Data is passed unmodified: no scaling, rounding or sign change.
// TESTING
//  (N=16 for all; x[n]: re=n, im=-n unless stated)
//  1 Basic frame: 16 contiguous valids, sof on n=0.
//    -> 4 out_valid pulses, each 1 cycle after n=12..15 accepted.
//    -> Pulse k=0: a=0,b=4,c=8,d=12 (im negated), exp=(0,0,0).
//    -> Pulse k=3: a=3,b=7,c=11,d=15, exp=(3,6,9), out_last=1.
//  2 Gapped input: same frame, in_valid low 2 cycles after every sample.
//    -> Identical outputs and order.
//    -> Each out_valid 1 cycle after its d sample; no spurious pulses.
//  3 Back-to-back frames: 32 contiguous samples re=n.
//    -> Frame-1 pulse k=0 gives a=16,b=20,c=24,d=28.
//    -> 8 pulses total, out_last on 4th and 8th.
//  4 Resync: sof at n=0; 6 samples; then sof and a full frame re=100+m.
//    -> No output for the partial frame.
//    -> Then k=0 gives a=100,b=104,c=108,d=112.
//  5 Reset mid-frame: reset asserted 1 cycle after 13 samples accepted (k=0 pulse pending).
//    -> out_valid=0 and all outputs 0 the cycle after reset.
//    -> Next full frame produces correct outputs.
//  6 Extreme values: re=2^(WIDTH-1)-1, im=-2^(WIDTH-1) on every sample.
//    -> Values appear bit-exact on all eight data outputs.

Source files
------------

// File: rtl/radix4_sdf_gather.sv
// Input gather stage of a radix-4 SDF FFT stage: buffers quarters 0..2 of each frame and
// presents x[k], x[k+N/4], x[k+N/2], x[k+3N/4] plus twiddle exponents as quarter-3 arrives.
module radix4_sdf_gather #(
  parameter int WIDTH = 32,
  parameter int N     = 64,
  localparam int LOG2N = $clog2(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             out_valid,
  output logic             out_last,
  output logic [WIDTH-1:0] ar,
  output logic [WIDTH-1:0] ai,
  output logic [WIDTH-1:0] br,
  output logic [WIDTH-1:0] bi,
  output logic [WIDTH-1:0] cr,
  output logic [WIDTH-1:0] ci,
  output logic [WIDTH-1:0] dr,
  output logic [WIDTH-1:0] di,
  output logic [LOG2N-1:0] w0_exp,
  output logic [LOG2N-1:0] w1_exp,
  output logic [LOG2N-1:0] w2_exp
);

  localparam int Q  = N / 4;
  localparam int KW = LOG2N - 2;

  // state | meaning
  // FILL0 | quarter 0 arriving, stored in buf0
  // FILL1 | quarter 1 arriving, stored in buf1
  // FILL2 | quarter 2 arriving, stored in buf2
  // EMIT  | quarter 3 arriving, butterfly inputs registered
  typedef enum logic [1:0] {FILL0 = 2'd0, FILL1 = 2'd1, FILL2 = 2'd2, EMIT = 2'd3} state_t;

  logic [LOG2N-1:0] idx_q, idx_d, eff_idx;
  state_t           state;
  logic [KW-1:0]    k;

  logic [2*WIDTH-1:0] buf0_mem [Q];
  logic [2*WIDTH-1:0] buf1_mem [Q];
  logic [2*WIDTH-1:0] buf2_mem [Q];

  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [2*WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [LOG2N-1:0]   w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;

  // A start-of-frame sample always lands at index 0, dropping any partial frame.
  always_comb begin
    eff_idx = in_sof ? '0 : idx_q;
    state   = state_t'(eff_idx[LOG2N-1:LOG2N-2]);
    k       = eff_idx[KW-1:0];
  end

  always_ff @(posedge clock) begin
    if (in_valid) begin
      case (state)
        FILL0:   buf0_mem[k] <= {in_re, in_im};
        FILL1:   buf1_mem[k] <= {in_re, in_im};
        FILL2:   buf2_mem[k] <= {in_re, in_im};
        default: ;
      endcase
    end
  end

  always_comb begin
    idx_d       = idx_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    d_d         = d_q;
    w0_d        = w0_q;
    w1_d        = w1_q;
    w2_d        = w2_q;
    if (in_valid) begin
      idx_d = eff_idx + 1'b1;
      if (state == EMIT) begin
        out_valid_d = 1'b1;
        out_last_d  = (k == '1);
        a_d         = buf0_mem[k];
        b_d         = buf1_mem[k];
        c_d         = buf2_mem[k];
        d_d         = {in_re, in_im};
        // 3k stays below N, so plain LOG2N-bit arithmetic never overflows.
        w0_d        = {2'b00, k};
        w1_d        = {1'b0, k, 1'b0};
        w2_d        = {2'b00, k} + {1'b0, k, 1'b0};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      w0_q        <= '0;
      w1_q        <= '0;
      w2_q        <= '0;
    end else begin
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
      w0_q        <= w0_d;
      w1_q        <= w1_d;
      w2_q        <= w2_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign ar        = a_q[2*WIDTH-1:WIDTH];
  assign ai        = a_q[WIDTH-1:0];
  assign br        = b_q[2*WIDTH-1:WIDTH];
  assign bi        = b_q[WIDTH-1:0];
  assign cr        = c_q[2*WIDTH-1:WIDTH];
  assign ci        = c_q[WIDTH-1:0];
  assign dr        = d_q[2*WIDTH-1:WIDTH];
  assign di        = d_q[WIDTH-1:0];
  assign w0_exp    = w0_q;
  assign w1_exp    = w1_q;
  assign w2_exp    = w2_q;

endmodule

// File: tb/tb_radix4_sdf_gather.sv
// Bench for radix4_sdf_gather (N=16): a frame-array reference model predicts every output each cycle.
module tb_radix4_sdf_gather;

  localparam int WIDTH = 32;
  localparam int N     = 16;

  logic        clock = 1'b0;
  logic        reset, in_valid, in_sof;
  logic [31:0] in_re, in_im;
  logic        out_valid, out_last;
  logic [31:0] ar, ai, br, bi, cr, ci, dr, di;
  logic [3:0]  w0_exp, w1_exp, w2_exp;

  radix4_sdf_gather #(.WIDTH(WIDTH), .N(N)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_last(out_last),
    .ar(ar), .ai(ai), .br(br), .bi(bi), .cr(cr), .ci(ci), .dr(dr), .di(di),
    .w0_exp(w0_exp), .w1_exp(w1_exp), .w2_exp(w2_exp)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: x[n] of the current frame, position of the next sample, predicted outputs.
  logic [31:0] fr_re [16];
  logic [31:0] fr_im [16];
  int          pos;
  logic        m_valid, m_last;
  logic [31:0] m_dat [8];
  logic [3:0]  m_w [3];

  wire [269:0] dut_vec = {out_valid, out_last, ar, ai, br, bi, cr, ci, dr, di, w0_exp, w1_exp, w2_exp};

  function automatic logic [269:0] exp_vec();
    return {m_valid, m_last, m_dat[0], m_dat[1], m_dat[2], m_dat[3], m_dat[4], m_dat[5],
            m_dat[6], m_dat[7], m_w[0], m_w[1], m_w[2]};
  endfunction

  task automatic step(input logic rst, input logic v, input logic s,
                      input logic [31:0] re, input logic [31:0] im);
    int p, kk;
    reset = rst; in_valid = v; in_sof = s; in_re = re; in_im = im;
    if (rst) begin
      pos = 0; m_valid = 1'b0; m_last = 1'b0;
      for (int i = 0; i < 8; i++) m_dat[i] = '0;
      for (int i = 0; i < 3; i++) m_w[i] = '0;
    end else begin
      m_valid = 1'b0; m_last = 1'b0;
      if (v) begin
        p = s ? 0 : pos;
        fr_re[p] = re; fr_im[p] = im;
        if (p >= 3 * N / 4) begin
          kk = p - 3 * N / 4;
          m_valid = 1'b1;
          m_last  = (kk == N / 4 - 1);
          for (int j = 0; j < 4; j++) begin
            m_dat[2*j]   = fr_re[kk + j * N / 4];
            m_dat[2*j+1] = fr_im[kk + j * N / 4];
          end
          m_w[0] = 4'(kk); m_w[1] = 4'(2 * kk); m_w[2] = 4'(3 * kk);
        end
        pos = (p + 1) % N;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b1, 1'b1, $urandom, $urandom);
    checks++;
    if (dut_vec !== 270'd0) begin
      errors++; $display("FAIL reset_zero got %h want 0", dut_vec);
    end
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_idle got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_basic();
    for (int n = 0; n < 16; n++) begin
      step(1'b0, 1'b1, n == 0, n, -n);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL basic n=%0d got %h want %h", n, dut_vec, exp_vec());
      end
      if (n == 12) begin
        checks++;
        if ({out_valid, out_last, ar, br, cr, dr, di, w0_exp, w1_exp, w2_exp} !==
            {1'b1, 1'b0, 32'd0, 32'd4, 32'd8, 32'd12, 32'hFFFF_FFF4, 4'd0, 4'd0, 4'd0}) begin
          errors++; $display("FAIL basic_k0 got a=%0d b=%0d c=%0d d=%0d", ar, br, cr, dr);
        end
      end
      if (n == 15) begin
        checks++;
        if ({out_valid, out_last, ar, br, cr, dr, di, w0_exp, w1_exp, w2_exp} !==
            {1'b1, 1'b1, 32'd3, 32'd7, 32'd11, 32'd15, 32'hFFFF_FFF1, 4'd3, 4'd6, 4'd9}) begin
          errors++; $display("FAIL basic_k3 got a=%0d d=%0d w=%0d/%0d/%0d last=%b",
                             ar, dr, w0_exp, w1_exp, w2_exp, out_last);
        end
      end
    end
  endtask

  task automatic test_gapped();
    for (int n = 0; n < 16; n++) begin
      step(1'b0, 1'b1, n == 0, n, -n);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL gapped n=%0d got %h want %h", n, dut_vec, exp_vec());
      end
      for (int g = 0; g < 2; g++) begin
        step(1'b0, 1'b0, 1'b0, $urandom, $urandom);
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++; $display("FAIL gapped_idle n=%0d got %h want %h", n, dut_vec, exp_vec());
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int lasts = 0;
    for (int n = 0; n < 32; n++) begin
      step(1'b0, 1'b1, n == 0, n, $urandom);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL b2b n=%0d got %h want %h", n, dut_vec, exp_vec());
      end
      if (out_valid) pulses++;
      if (out_valid && out_last) lasts++;
      if (n == 28) begin
        checks++;
        if ({ar, br, cr, dr} !== {32'd16, 32'd20, 32'd24, 32'd28}) begin
          errors++; $display("FAIL b2b_f1k0 got a=%0d b=%0d c=%0d d=%0d want 16/20/24/28", ar, br, cr, dr);
        end
      end
    end
    checks++;
    if (pulses != 8 || lasts != 2) begin
      errors++; $display("FAIL b2b_count got pulses=%0d lasts=%0d want 8 2", pulses, lasts);
    end
  endtask

  task automatic test_resync();
    for (int n = 0; n < 6; n++) begin
      step(1'b0, 1'b1, n == 0, n, $urandom);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL resync_part n=%0d got %h want %h", n, dut_vec, exp_vec());
      end
    end
    for (int m = 0; m < 16; m++) begin
      step(1'b0, 1'b1, m == 0, 100 + m, $urandom);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL resync m=%0d got %h want %h", m, dut_vec, exp_vec());
      end
      if (m == 12) begin
        checks++;
        if ({out_valid, ar, br, cr, dr} !== {1'b1, 32'd100, 32'd104, 32'd108, 32'd112}) begin
          errors++; $display("FAIL resync_k0 got v=%b a=%0d b=%0d c=%0d d=%0d", out_valid, ar, br, cr, dr);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n < 13; n++) begin
      step(1'b0, 1'b1, n == 0, $urandom, $urandom);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL rmid_pre n=%0d got %h want %h", n, dut_vec, exp_vec());
      end
    end
    step(1'b1, 1'b1, 1'b0, $urandom, $urandom);
    checks++;
    if (dut_vec !== 270'd0) begin
      errors++; $display("FAIL rmid_zero got %h want 0", dut_vec);
    end
    for (int n = 0; n < 16; n++) begin
      step(1'b0, 1'b1, 1'b0, $urandom, $urandom);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL rmid_post n=%0d got %h want %h", n, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_extreme();
    for (int n = 0; n < 16; n++) begin
      step(1'b0, 1'b1, n == 0, 32'h7FFF_FFFF, 32'h8000_0000);
      if (n >= 12) begin
        checks++;
        if ({out_valid, ar, ai, br, bi, cr, ci, dr, di} !==
            {1'b1, {4{32'h7FFF_FFFF, 32'h8000_0000}}}) begin
          errors++; $display("FAIL extreme n=%0d got %h", n, {ar, ai, br, bi, cr, ci, dr, di});
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
           $urandom, $urandom);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random c=%0d got %h want %h", c, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_re = '0; in_im = '0;
    test_reset();
    test_basic();
    test_gapped();
    test_back_to_back();
    test_resync();
    test_reset_mid();
    test_extreme();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
